// File: rtl/sample_voice_mixer.sv
// Multi-voice ROM sample player: per-voice address sequencers, a shared
// fetch/sum/wait/write sequencer, and a mixed sample handed to the codec FIFO.
module sample_voice_mixer #(
  parameter int CHANNELS = 3,
  parameter int SAMPLE_W = 10,
  parameter int ADDR_W   = 20,
  parameter int OUT_W    = 12
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic [CHANNELS-1:0]          play,
  input  logic [CHANNELS-1:0]          hold_mode,
  input  logic [CHANNELS*ADDR_W-1:0]   address_max,
  output logic [CHANNELS*ADDR_W-1:0]   rom_address,
  input  logic [CHANNELS*SAMPLE_W-1:0] rom_q,
  input  logic                         audio_out_allowed,
  output logic                         write_audio_out,
  output logic                         clear_buffer,
  output logic [OUT_W-1:0]             audio_out,
  output logic [CHANNELS-1:0]          active,
  output logic [CHANNELS-1:0]          done
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FETCH = 3'd1;
  localparam logic [2:0] S_SUM   = 3'd2;
  localparam logic [2:0] S_WAIT  = 3'd3;
  localparam logic [2:0] S_WRITE = 3'd4;

  logic [2:0]          state_q, state_d;
  logic [CHANNELS-1:0] prev_play_q, prev_play_d;
  logic [CHANNELS-1:0] pending_q, pending_d;
  logic [CHANNELS-1:0] on_q, on_d;
  logic [CHANNELS-1:0] hold_q, hold_d;
  logic [CHANNELS-1:0] done_q, done_d;
  logic                clear_q, clear_d;
  logic [OUT_W-1:0]    audio_q, audio_d;
  logic [ADDR_W-1:0]   addr_q [CHANNELS];
  logic [ADDR_W-1:0]   addr_d [CHANNELS];

  logic [ADDR_W-1:0]   max_w    [CHANNELS];
  logic [SAMPLE_W-1:0] sample_w [CHANNELS];
  logic [CHANNELS-1:0] trig;
  logic [CHANNELS-1:0] apply;
  logic                update_phase;
  logic [OUT_W-1:0]    mix_sum;

  for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_voice_io
    assign max_w[gi]                         = address_max[gi*ADDR_W +: ADDR_W];
    assign sample_w[gi]                      = rom_q[gi*SAMPLE_W +: SAMPLE_W];
    assign rom_address[gi*ADDR_W +: ADDR_W]  = addr_q[gi];
  end

  assign trig         = play & ~prev_play_q;
  assign update_phase = (state_q == S_WRITE);
  assign prev_play_d  = play;

  // Triggers take effect only between samples: immediately when idle,
  // otherwise they wait as pending until the write completes.
  always_comb begin
    apply = '0;
    if ((state_q == S_IDLE) || (state_q == S_WRITE)) begin
      apply = pending_q | trig;
    end
  end

  always_comb begin
    on_d      = on_q;
    hold_d    = hold_q;
    done_d    = '0;
    pending_d = pending_q | trig;
    for (int i = 0; i < CHANNELS; i++) begin
      addr_d[i] = addr_q[i];
      if (apply[i]) begin
        addr_d[i]    = '0;
        on_d[i]      = 1'b1;
        hold_d[i]    = hold_mode[i];
        pending_d[i] = 1'b0;
      end else if (update_phase && on_q[i]) begin
        if (hold_q[i] && !play[i]) begin
          on_d[i]   = 1'b0;
          done_d[i] = 1'b1;
        end else if (addr_q[i] < max_w[i]) begin
          addr_d[i] = addr_q[i] + ADDR_W'(1);
        end else if (hold_q[i]) begin
          addr_d[i] = '0;
        end else begin
          on_d[i]   = 1'b0;
          done_d[i] = 1'b1;
        end
      end
    end
  end

  // OUT_W is wide enough for the full sum, so plain wrap-free addition.
  always_comb begin
    mix_sum = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (on_q[i]) begin
        mix_sum = mix_sum + OUT_W'($signed(sample_w[i]));
      end
    end
  end

  always_comb begin
    state_d = state_q;
    clear_d = 1'b0;
    audio_d = audio_q;
    case (state_q)
      S_IDLE: begin
        if (|apply) state_d = S_FETCH;
      end
      S_FETCH: state_d = S_SUM;
      S_SUM: begin
        audio_d = mix_sum;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (audio_out_allowed) state_d = S_WRITE;
      end
      S_WRITE: begin
        if (|on_d) begin
          state_d = S_FETCH;
        end else begin
          state_d = S_IDLE;
          clear_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // A key held through reset must be released before it can trigger again.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= S_IDLE;
      prev_play_q <= '1;
      pending_q   <= '0;
      on_q        <= '0;
      hold_q      <= '0;
      done_q      <= '0;
      clear_q     <= 1'b0;
      audio_q     <= '0;
      for (int i = 0; i < CHANNELS; i++) begin
        addr_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      prev_play_q <= prev_play_d;
      pending_q   <= pending_d;
      on_q        <= on_d;
      hold_q      <= hold_d;
      done_q      <= done_d;
      clear_q     <= clear_d;
      audio_q     <= audio_d;
      for (int i = 0; i < CHANNELS; i++) begin
        addr_q[i] <= addr_d[i];
      end
    end
  end

  assign write_audio_out = update_phase;
  assign clear_buffer    = clear_q;
  assign audio_out       = audio_q;
  assign active          = on_q;
  assign done            = done_q;

endmodule

// File: tb/tb_sample_voice_mixer.sv
// Directed bench for sample_voice_mixer with a registered ROM model per voice.
module tb_sample_voice_mixer;
  localparam int CH = 3;
  localparam int SW = 10;
  localparam int AW = 20;
  localparam int OW = 12;

  logic             clock = 1'b0;
  logic             reset;
  logic [CH-1:0]    play, hold_mode, active, done;
  logic [CH*AW-1:0] address_max, rom_address;
  logic [CH*SW-1:0] rom_q;
  logic             audio_out_allowed, write_audio_out, clear_buffer;
  logic [OW-1:0]    audio_out;

  logic [SW-1:0] rom [CH][16];
  int            n_cmp = 0;
  int            n_mis = 0;
  logic [CH-1:0] done_acc;
  int            clear_acc;
  int            writes_acc;
  int            unstable;

  sample_voice_mixer #(.CHANNELS(CH), .SAMPLE_W(SW), .ADDR_W(AW), .OUT_W(OW)) dut (
    .clock             (clock),
    .reset             (reset),
    .play              (play),
    .hold_mode         (hold_mode),
    .address_max       (address_max),
    .rom_address       (rom_address),
    .rom_q             (rom_q),
    .audio_out_allowed (audio_out_allowed),
    .write_audio_out   (write_audio_out),
    .clear_buffer      (clear_buffer),
    .audio_out         (audio_out),
    .active            (active),
    .done              (done)
  );

  always #5 clock = ~clock;

  // ROM data appears one clock after the address.
  always @(posedge clock) begin
    for (int c = 0; c < CH; c++) begin
      rom_q[c*SW +: SW] <= rom[c][rom_address[c*AW +: 4]];
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
    done_acc |= done;
    if (clear_buffer) clear_acc++;
    if (write_audio_out) writes_acc++;
  endtask

  task automatic wait_write(input string tag, input int budget);
    int n;
    n = 0;
    step();
    while (!write_audio_out && n < budget) begin
      step();
      n++;
    end
    check(tag, write_audio_out, 1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_write"}, write_audio_out, 0);
    check({tag, "_clear"}, clear_buffer, 0);
    check({tag, "_audio"}, audio_out, 0);
    check({tag, "_active"}, active, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_romaddr_zero"}, (rom_address === '0), 1);
  endtask

  initial begin
    reset = 1'b1;
    play = '0;
    hold_mode = '0;
    address_max = '0;
    audio_out_allowed = 1'b1;
    done_acc = '0;
    clear_acc = 0;
    writes_acc = 0;
    unstable = 0;
    for (int c = 0; c < CH; c++) begin
      for (int a = 0; a < 16; a++) rom[c][a] = '0;
    end
    repeat (3) step();
    check_reset_outputs("rst");
    reset = 1'b0;
    step();

    // One-shot voice 0, four samples
    rom[0][0] = 10'd1; rom[0][1] = 10'd2; rom[0][2] = 10'd3; rom[0][3] = 10'd4;
    address_max[0 +: AW] = 20'd3;
    play[0] = 1'b1;
    step();
    check("os_active_t1", active, 3'b001);
    check("os_addr_t1", rom_address[0 +: AW], 0);
    step();
    step();
    check("os_nowrite_t3", write_audio_out, 0);
    play[0] = 1'b0;
    step();
    check("os_write_t4", write_audio_out, 1);
    check("os_audio0", audio_out, 1);
    for (int k = 1; k < 4; k++) begin
      repeat (3) step();
      check("os_gap", write_audio_out, 0);
      step();
      check("os_write", write_audio_out, 1);
      check("os_audio", audio_out, k + 1);
    end
    writes_acc = 0; done_acc = '0; clear_acc = 0;
    step();
    check("os_done", done, 3'b001);
    check("os_inactive", active, 3'b000);
    check("os_clear", clear_buffer, 1);
    step();
    check("os_done_single", done, 3'b000);
    repeat (10) step();
    check("os_no_more_writes", writes_acc, 0);
    check("os_clear_count", clear_acc, 1);

    // Hold-mode voice 1, loops 0,1,2 until release
    rom[1][0] = 10'd0; rom[1][1] = 10'd1; rom[1][2] = 10'd2;
    address_max[AW +: AW] = 20'd2;
    hold_mode = 3'b010;
    play[1] = 1'b1;
    for (int k = 0; k < 10; k++) begin
      wait_write("hold_write", 20);
      check("hold_audio", audio_out, k % 3);
    end
    step();
    play[1] = 1'b0;
    done_acc = '0; clear_acc = 0;
    wait_write("hold_last_write", 20);
    check("hold_last_audio", audio_out, 1);
    check("hold_no_early_done", done_acc, 3'b000);
    step();
    check("hold_done", done, 3'b010);
    check("hold_inactive", active, 3'b000);
    check("hold_clear", clear_buffer, 1);
    hold_mode = '0;

    // Mixing with signed samples, then full-scale sum
    rom[0][0] = 10'd500; rom[2][0] = 10'h2D4;
    address_max = '0;
    play = 3'b101;
    wait_write("mix2_write", 20);
    check("mix2_audio", audio_out, 200);
    step();
    check("mix2_done", done, 3'b101);
    play = '0;
    step();
    rom[0][0] = 10'd511; rom[1][0] = 10'd511; rom[2][0] = 10'd511;
    play = 3'b111;
    wait_write("mix3_write", 20);
    check("mix3_audio", audio_out, 1533);
    step();
    check("mix3_done", done, 3'b111);
    play = '0;
    step();

    // Retrigger voice 0 at address 2
    rom[0][0] = 10'd10; rom[0][1] = 10'd20; rom[0][2] = 10'd30; rom[0][3] = 10'd40;
    address_max[0 +: AW] = 20'd3;
    play[0] = 1'b1;
    done_acc = '0;
    wait_write("rt_w0", 20);
    check("rt_a0", audio_out, 10);
    wait_write("rt_w1", 20);
    check("rt_a1", audio_out, 20);
    step();
    play[0] = 1'b0;
    check("rt_addr2", rom_address[0 +: AW], 2);
    step();
    play[0] = 1'b1;
    wait_write("rt_w2", 20);
    check("rt_a2", audio_out, 30);
    wait_write("rt_w3", 20);
    check("rt_restart", audio_out, 10);
    check("rt_no_done", done_acc, 3'b000);
    for (int k = 2; k <= 4; k++) begin
      wait_write("rt_tail_write", 20);
      check("rt_tail_audio", audio_out, k * 10);
    end
    step();
    check("rt_done", done, 3'b001);
    play = '0;
    step();

    // Backpressure: allowed held low in S_WAIT
    rom[0][0] = 10'd77;
    address_max[0 +: AW] = 20'd0;
    audio_out_allowed = 1'b0;
    play[0] = 1'b1;
    repeat (3) step();
    check("bp_audio_in_wait", audio_out, 77);
    writes_acc = 0;
    unstable = 0;
    repeat (20) begin
      step();
      if (audio_out !== 12'd77) unstable++;
    end
    check("bp_no_write", writes_acc, 0);
    check("bp_audio_stable", unstable, 0);
    audio_out_allowed = 1'b1;
    step();
    check("bp_write_after_allow", write_audio_out, 1);
    check("bp_audio_written", audio_out, 77);
    step();
    check("bp_done", done, 3'b001);
    play = '0;
    step();

    // Reset in mid-play with the key still held
    rom[0][0] = 10'd5; rom[0][1] = 10'd6; rom[0][2] = 10'd7; rom[0][3] = 10'd8;
    address_max[0 +: AW] = 20'd3;
    play[0] = 1'b1;
    wait_write("mr_first_write", 20);
    check("mr_first_audio", audio_out, 5);
    step();
    step();
    reset = 1'b1;
    step();
    check_reset_outputs("mr");
    reset = 1'b0;
    writes_acc = 0; clear_acc = 0;
    repeat (10) step();
    check("mr_no_retrigger", active, 3'b000);
    check("mr_no_writes", writes_acc, 0);
    check("mr_no_clear", clear_acc, 0);
    play[0] = 1'b0;
    step();
    play[0] = 1'b1;
    step();
    check("mr_retrigger_after_release", active, 3'b001);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule
